// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed program image from a byte source into instruction memory
// and holds the CPU core in reset until the image is complete. Optional checksum via BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DAT_WIDTH  = 32,
    parameter int                    MAX_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DAT_WIDTH-1:0]  imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  done,
    output logic                  error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_WRAP, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_WRAP, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_WRAP;
`endif

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q;
    logic [31:0]        len_q;
    logic [31:0]        word_q;
    logic [IDX_W-1:0]   word_idx_q;
    logic               accept;
    logic               last_byte;
    logic               last_word;
    logic               in_chk;
    logic [31:0]        full_word;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]        sum_q;
`endif

`ifdef BOOT_CHECKSUM_EN
    assign in_chk = (state_q == S_CHK);
`else
    assign in_chk = 1'b0;
`endif

    // A byte offered during restart is refused so that the new image starts cleanly.
    assign s_ready   = !restart && ((state_q == S_LEN) || (state_q == S_DATA) || in_chk);
    assign accept    = s_valid && s_ready;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    assign full_word = {s_data, word_q[23:0]};
    assign last_word = (32'(word_idx_q) + 32'd1) == len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = S_LEN;
        end else begin
            case (state_q)
                S_LEN: begin
                    if (last_byte) begin
                        if (full_word == 32'd0) begin
                            state_d = S_AFTER_DATA;
                        end else if (full_word > 32'(MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last_byte && last_word) begin
                        state_d = S_AFTER_DATA;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CHK: begin
                    if (last_byte) begin
                        state_d = (full_word == sum_q) ? S_WRAP : S_ERR;
                    end
                end
`endif
                S_WRAP:  state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_LEN;
            endcase
        end
    end

    // Status outputs are registered from the next state so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= 2'd0;
            len_q      <= 32'd0;
            word_q     <= 32'd0;
            word_idx_q <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            imem_we   <= 1'b0;
            done      <= (state_d == S_DONE);
            cpu_rst_n <= (state_d == S_DONE);
            error     <= (state_d == S_ERR);
            if (restart) begin
                byte_cnt_q <= 2'd0;
                len_q      <= 32'd0;
                word_q     <= 32'd0;
                word_idx_q <= '0;
                imem_addr  <= BASE_ADDR;
`ifdef BOOT_CHECKSUM_EN
                sum_q      <= 32'd0;
`endif
            end else begin
                if (accept) begin
                    byte_cnt_q                         <= byte_cnt_q + 2'd1;
                    word_q[{byte_cnt_q, 3'b000} +: 8] <= s_data;
                end
                if (last_byte && (state_q == S_LEN)) begin
                    len_q <= full_word;
                end
                if (last_byte && (state_q == S_DATA)) begin
                    imem_we    <= 1'b1;
                    imem_wdata <= DAT_WIDTH'(full_word);
                    imem_addr  <= BASE_ADDR + (ADDR_WIDTH'(word_idx_q) << 2);
                    word_idx_q <= word_idx_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                    sum_q      <= sum_q + full_word;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed steps with randomized gaps and images,
// checked against an address/data model derived from the image contents.
module tb_imem_boot_loader;

    localparam int          ADDR_WIDTH = 32;
    localparam int          DAT_WIDTH  = 32;
    localparam int          MAX_WORDS  = 1024;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_1000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  s_valid = 1'b0;
    logic [7:0]            s_data = 8'h00;
    logic                  s_ready;
    logic                  restart = 1'b0;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DAT_WIDTH-1:0]  imem_wdata;
    logic                  cpu_rst_n;
    logic                  done;
    logic                  error;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cycle = 0;
    int          lastAcceptCycle = 0;
    int          lastWeCycle = -100;
    int          weViolations = 0;
    logic [63:0] obsQ[$];
    logic [31:0] imgWords[$];
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] csumDelta = 32'd0;
`endif

    imem_boot_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DAT_WIDTH (DAT_WIDTH),
        .MAX_WORDS (MAX_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .restart   (restart),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Write monitor: records every write and flags any two writes closer than 4 cycles.
    always @(negedge clk) begin
        if (rst_n && imem_we === 1'b1) begin
            if (cycle - lastWeCycle < 4) weViolations++;
            lastWeCycle = cycle;
            obsQ.push_back({imem_addr, imem_wdata});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic syncPos();
        @(posedge clk);
        #1;
    endtask

    // Offers one byte after a random idle gap and waits for it to be taken.
    task automatic applyStimulus(input logic [7:0] b, input int maxGap);
        logic taken = 1'b0;
        int   gap = int'($urandom_range(maxGap, 0));
        repeat (gap) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            syncPos();
        end
        s_valid = 1'b1;
        s_data  = b;
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            taken = (s_ready === 1'b1);
            syncPos();
        end
        s_valid = 1'b0;
        lastAcceptCycle = cycle;
        if (!taken) checkOutput("byte_accept", {63'd0, taken}, 64'd1);
    endtask

    task automatic sendWord(input logic [31:0] w, input int maxGap);
        for (int b = 0; b < 4; b++) applyStimulus(w[8*b +: 8], maxGap);
    endtask

`ifdef BOOT_CHECKSUM_EN
    function automatic logic [31:0] imageSum();
        logic [31:0] s = 32'd0;
        foreach (imgWords[i]) s += imgWords[i];
        return s;
    endfunction
`endif

    task automatic loadImage(input int maxGap);
        obsQ.delete();
        sendWord(32'(imgWords.size()), maxGap);
        foreach (imgWords[i]) sendWord(imgWords[i], maxGap);
`ifdef BOOT_CHECKSUM_EN
        sendWord(imageSum() + csumDelta, maxGap);
`endif
    endtask

    // Expected writes are BASE_ADDR + 4*i carrying image word i; CPU released two cycles after the last byte.
    task automatic checkLoad(input string tag);
        @(negedge clk);
        checkOutput({tag, "_wrap_done"}, {63'd0, done}, 64'd0);
        checkOutput({tag, "_wrap_cpu"}, {63'd0, cpu_rst_n}, 64'd0);
        @(negedge clk);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, 64'd1);
        checkOutput({tag, "_error"}, {63'd0, error}, 64'd0);
        checkOutput({tag, "_ready"}, {63'd0, s_ready}, 64'd0);
        checkOutput({tag, "_nwrites"}, 64'(obsQ.size()), 64'(imgWords.size()));
        foreach (imgWords[i]) begin
            if (i < obsQ.size())
                checkOutput({tag, "_write"}, obsQ[i], {BASE_ADDR + 32'(4 * i), imgWords[i]});
        end
`ifndef BOOT_CHECKSUM_EN
        if (imgWords.size() > 0)
            checkOutput({tag, "_last_we_cycle"}, 64'(lastWeCycle), 64'(lastAcceptCycle));
`endif
        syncPos();
    endtask

    task automatic pulseRestart(input logic withByte);
        restart = 1'b1;
        s_valid = withByte;
        s_data  = 8'hFF;
        @(negedge clk);
        checkOutput("restart_ready", {63'd0, s_ready}, 64'd0);
        syncPos();
        restart = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        checkOutput("restart_cpu", {63'd0, cpu_rst_n}, 64'd0);
        checkOutput("restart_done", {63'd0, done}, 64'd0);
        checkOutput("restart_error", {63'd0, error}, 64'd0);
        checkOutput("restart_rearm", {63'd0, s_ready}, 64'd1);
        syncPos();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        // Reset values while rst_n is low, then ready after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_we", {63'd0, imem_we}, 64'd0);
        checkOutput("rst_addr", 64'(imem_addr), 64'(BASE_ADDR));
        checkOutput("rst_wdata", 64'(imem_wdata), 64'd0);
        checkOutput("rst_cpu", {63'd0, cpu_rst_n}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_error", {63'd0, error}, 64'd0);
        rst_n = 1'b1;
        syncPos();
        @(negedge clk);
        checkOutput("rel_ready", {63'd0, s_ready}, 64'd1);
        checkOutput("rel_cpu", {63'd0, cpu_rst_n}, 64'd0);
        syncPos();

        // Two-word reference image, back-to-back.
        imgWords = '{32'h0000_0013, 32'h0010_0093};
        loadImage(0);
        checkLoad("basic");

        // Trailing bytes are refused once done.
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (2) begin
            @(negedge clk);
            checkOutput("done_hold_ready", {63'd0, s_ready}, 64'd0);
        end
        s_valid = 1'b0;
        syncPos();

        // Restart in DONE, then the same image with random stalls.
        pulseRestart(1'b0);
        weViolations = 0;
        loadImage(3);
        checkLoad("gaps");
        checkOutput("we_spacing", 64'(weViolations), 64'd0);

        // Restart mid-word with a byte offered the same cycle; partial word discarded.
        pulseRestart(1'b0);
        obsQ.delete();
        sendWord(32'd3, 0);
        sendWord(32'hDEAD_BEEF, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        pulseRestart(1'b1);
        checkOutput("partial_writes", 64'(obsQ.size()), 64'd1);
        imgWords = '{};
        repeat (4) imgWords.push_back($urandom);
        loadImage(2);
        checkLoad("fresh");

        // Oversized length is rejected without any write.
        pulseRestart(1'b0);
        obsQ.delete();
        sendWord(32'h0000_0401, 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("err_flag", {63'd0, error}, 64'd1);
            checkOutput("err_cpu", {63'd0, cpu_rst_n}, 64'd0);
            checkOutput("err_ready", {63'd0, s_ready}, 64'd0);
        end
        checkOutput("err_nwrites", 64'(obsQ.size()), 64'd0);
        syncPos();
        pulseRestart(1'b0);

        // Length exactly MAX_WORDS is accepted.
        sendWord(32'(MAX_WORDS), 0);
        @(negedge clk);
        checkOutput("max_error", {63'd0, error}, 64'd0);
        checkOutput("max_ready", {63'd0, s_ready}, 64'd1);
        syncPos();
        pulseRestart(1'b0);

        // Empty image.
        imgWords = '{};
        loadImage(1);
        checkLoad("empty");

        // Random images with random stalls.
        for (int n = 0; n < 3; n++) begin
            pulseRestart(1'b0);
            imgWords = '{};
            repeat ($urandom_range(6, 1)) imgWords.push_back($urandom);
            weViolations = 0;
            loadImage(3);
            checkLoad("random");
            checkOutput("random_spacing", 64'(weViolations), 64'd0);
        end

        // Asynchronous reset mid-image abandons it.
        pulseRestart(1'b0);
        obsQ.delete();
        sendWord(32'd2, 1);
        sendWord(32'h0BAD_F00D, 1);
        applyStimulus(8'h77, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_we", {63'd0, imem_we}, 64'd0);
        checkOutput("arst_addr", 64'(imem_addr), 64'(BASE_ADDR));
        checkOutput("arst_cpu", {63'd0, cpu_rst_n}, 64'd0);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        repeat (6) syncPos();
        checkOutput("arst_nwrites", 64'(obsQ.size()), 64'd1);
        imgWords = '{32'h0000_0013, 32'h0010_0093, 32'h1234_5678};
        loadImage(1);
        checkLoad("after_arst");

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum is rejected and the CPU stays in reset.
        pulseRestart(1'b0);
        imgWords  = '{32'h0000_0013, 32'h0010_0093};
        csumDelta = 32'd1;
        loadImage(0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("csum_err", {63'd0, error}, 64'd1);
            checkOutput("csum_cpu", {63'd0, cpu_rst_n}, 64'd0);
            checkOutput("csum_done", {63'd0, done}, 64'd0);
        end
        csumDelta = 32'd0;
        syncPos();
        pulseRestart(1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
